// File: rtl/bus_pkg.sv
// Shared constants and helpers for the round-robin bus multiplexer family.
package bus_pkg;

  localparam int BUS_WIDTH  = 4;
  localparam int BUS_NUM_IN = 4;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Ceiling log2 for tools that lack a usable $clog2; returns at least 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational arbiter: picks one requester, either round-robin from ptr
// or lowest index first, and returns a one-hot grant plus its index.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_IN     = BUS_NUM_IN,
  parameter int SEL_W      = $clog2(NUM_IN),
  parameter int FIXED_PRIO = ARB_RR
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic             found;
  logic [SEL_W:0]   cand;

  // Scan candidates starting at ptr (or 0 in fixed mode) and take the first
  // requester; the grant vector is only driven when the caller enables it.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (FIXED_PRIO == ARB_FIXED) begin
        cand = (SEL_W+1)'(k);
      end else begin
        cand = {1'b0, ptr} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(NUM_IN)) cand = cand - (SEL_W+1)'(NUM_IN);
      end
      if (!found && req[cand[SEL_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SEL_W-1:0];
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_rr_mux.sv
// N-to-1 bus multiplexer with round-robin or fixed-priority arbitration and
// a registered valid/ready output stage. out_ready reaches in_ready
// combinationally; in_valid never reaches out_valid combinationally.
module bus_rr_mux
  import bus_pkg::*;
#(
  parameter int WIDTH      = BUS_WIDTH,
  parameter int NUM_IN     = BUS_NUM_IN,
  parameter int SEL_W      = $clog2(NUM_IN),
  parameter int FIXED_PRIO = ARB_RR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  logic             any_req;
  logic             arb_en;

  // The slot can take a word when empty or when its word leaves this cycle.
  // Grants are suppressed while reset is held so nothing looks accepted.
  assign load_en  = !out_valid || out_ready;
  assign any_req  = |in_valid;
  assign arb_en   = load_en && rst_n;
  assign sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  bus_rr_arbiter #(
    .NUM_IN     (NUM_IN),
    .SEL_W      (SEL_W),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (in_ready),
    .grant_idx (grant_idx)
  );

  // Output register and round-robin pointer: load on accept, empty when
  // idle, hold everything while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        ptr       <= (grant_idx == SEL_W'(NUM_IN-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_mux.sv
// Directed bench for bus_rr_mux: one round-robin and one fixed-priority
// instance driven from the same inputs.
`timescale 1ns/1ps
module tb_bus_rr_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic [3:0]  rr_in_ready;
  logic        rr_out_valid;
  logic [3:0]  rr_out_data;
  logic [1:0]  rr_out_sel;

  logic [3:0]  fp_in_ready;
  logic        fp_out_valid;
  logic [3:0]  fp_out_data;
  logic [1:0]  fp_out_sel;

  int compared;
  int mismatched;

  bus_rr_mux #(.WIDTH(4), .NUM_IN(4), .FIXED_PRIO(0)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_ready (out_ready)
  );

  bus_rr_mux #(.WIDTH(4), .NUM_IN(4), .FIXED_PRIO(1)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    step();
    step();

    // Reset held with every channel requesting
    checkOutput("rst_out_valid", 32'(rr_out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(rr_out_data),  32'h0);
    checkOutput("rst_out_sel",   32'(rr_out_sel),   32'd0);
    checkOutput("rst_in_ready",  32'(rr_in_ready),  32'b0000);
    checkOutput("rst_fp_in_ready", 32'(fp_in_ready), 32'b0000);
    checkOutput("rst_fp_out_valid", 32'(fp_out_valid), 32'd0);

    // Single channel 2
    rst_n = 1'b1;
    applyStimulus(4'b0100, 16'h0A00, 1'b1);
    checkOutput("single_in_ready", 32'(rr_in_ready), 32'b0100);
    step();
    checkOutput("single_out_valid", 32'(rr_out_valid), 32'd1);
    checkOutput("single_out_data",  32'(rr_out_data),  32'hA);
    checkOutput("single_out_sel",   32'(rr_out_sel),   32'd2);

    // Skip and wrap: ptr is now 3, only ch0/ch1 request
    applyStimulus(4'b0011, 16'h4321, 1'b1);
    checkOutput("wrap_in_ready0", 32'(rr_in_ready), 32'b0001);
    step();
    checkOutput("wrap_out_sel0",  32'(rr_out_sel),  32'd0);
    checkOutput("wrap_out_data0", 32'(rr_out_data), 32'h1);
    checkOutput("wrap_in_ready1", 32'(rr_in_ready), 32'b0010);
    step();
    checkOutput("wrap_out_sel1",  32'(rr_out_sel),  32'd1);
    checkOutput("wrap_out_data1", 32'(rr_out_data), 32'h2);

    // Idle cycle: slot empties, data and sel hold
    applyStimulus(4'b0000, 16'h4321, 1'b1);
    checkOutput("idle_in_ready", 32'(rr_in_ready), 32'b0000);
    step();
    checkOutput("idle_out_valid", 32'(rr_out_valid), 32'd0);
    checkOutput("idle_out_data",  32'(rr_out_data),  32'h2);
    checkOutput("idle_out_sel",   32'(rr_out_sel),   32'd1);

    // Asynchronous reset pulse between edges brings ptr back to 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // Fairness: all channels requesting, data ch i = i+1
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("fair_out_sel",  32'(rr_out_sel),  32'(i % 4));
      checkOutput("fair_out_data", 32'(rr_out_data), 32'(i % 4 + 1));
    end

    // Backpressure: load ch1 (0x5), then stall with everyone requesting
    applyStimulus(4'b0010, 16'h4351, 1'b1);
    step();
    checkOutput("bp_load_sel",  32'(rr_out_sel),  32'd1);
    checkOutput("bp_load_data", 32'(rr_out_data), 32'h5);
    applyStimulus(4'b1111, 16'h4351, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", 32'(rr_in_ready), 32'b0000);
      step();
      checkOutput("bp_out_data",  32'(rr_out_data),  32'h5);
      checkOutput("bp_out_valid", 32'(rr_out_valid), 32'd1);
    end
    applyStimulus(4'b1111, 16'h4351, 1'b1);
    checkOutput("bp_release_in_ready", 32'(rr_in_ready), 32'b0100);
    step();
    checkOutput("bp_release_sel",  32'(rr_out_sel),  32'd2);
    checkOutput("bp_release_data", 32'(rr_out_data), 32'h3);

    // Reset mid-stall: out_valid drops before the next edge
    applyStimulus(4'b1111, 16'h4351, 1'b0);
    step();
    checkOutput("stall_out_valid", 32'(rr_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(rr_out_valid), 32'd0);
    checkOutput("async_rst_out_data",  32'(rr_out_data),  32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    checkOutput("post_rst_in_ready", 32'(rr_in_ready), 32'b0001);

    // Fixed priority: ch1 always beats ch3
    applyStimulus(4'b1010, 16'h4321, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fp_in_ready", 32'(fp_in_ready), 32'b0010);
      step();
      checkOutput("fp_out_sel",  32'(fp_out_sel),  32'd1);
      checkOutput("fp_out_data", 32'(fp_out_data), 32'h2);
    end
    applyStimulus(4'b1000, 16'h4321, 1'b1);
    checkOutput("fp_ch3_in_ready", 32'(fp_in_ready), 32'b1000);
    step();
    checkOutput("fp_ch3_out_sel",  32'(fp_out_sel),  32'd3);
    checkOutput("fp_ch3_out_data", 32'(fp_out_data), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_rr_mux.md
Name: bus_rr_mux

Overview:
- Parametrised successor to the team's 2:1 bus select.
- Selects one of NUM_IN WIDTH-bit input channels and forwards it through a registered valid/ready output stage.
- Arbitration is round-robin or fixed-priority, chosen by a parameter.
- Sits between multiple bus producers (e.g. pipeline stages, memory ports) and a single shared consumer.

Parameters:
- WIDTH, 4, data bits per channel.
- NUM_IN, 4, number of input channels (>= 2).
- SEL_W, $clog2(NUM_IN), width of channel index.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = lowest index always wins.

Ports:
- clk  input  1  clock, rising edge. One clock; reset is asynchronous and active-low.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_IN  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_IN*WIDTH  flattened channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  one-hot grant/accept; channel i is consumed on a cycle where in_valid[i] && in_ready[i].
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sel=0, rr pointer=0. in_ready reads 0 because no grant is active.
- load_en = !out_valid || out_ready. The output slot is free, or is being drained this cycle.
- Grant (combinational):
  - Round-robin: first i with in_valid[i]=1, searching from ptr upward modulo NUM_IN.
  - FIXED_PRIO=1: lowest index with in_valid set; ptr is ignored.
- in_ready[g] = load_en && any in_valid, for grant g only. All other bits are 0. in_ready is never set for a channel whose in_valid is 0.
- On a clock edge with load_en && any in_valid:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g == NUM_IN-1) ? 0 : g+1.
- On a clock edge with load_en && no in_valid: out_valid <= 0. out_data and out_sel hold their last values.
- On a clock edge with out_valid && !out_ready (stall): out_data, out_sel, out_valid and ptr hold. in_ready is all 0.
- Latency: 1 cycle, input accept to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- Simultaneous drain and load: a word can be accepted in the same cycle the previous word leaves. There is no bubble.
- Fairness: under continuous requests from all channels, round-robin grants cycle 0,1,..,NUM_IN-1,0.
- A channel that deasserts in_valid before being granted loses nothing and does not move ptr.
- Wrap-around: ptr wraps from NUM_IN-1 to 0. The search wraps past NUM_IN-1 to 0.
- Reset mid-transfer: any held word is discarded, out_valid drops immediately (asynchronously), and ptr returns to 0.
- Combinational path out_ready -> in_ready is permitted and documented.
- The block contains no combinational path from in_valid to out_valid.

Decomposition:
- Shared package bus_pkg holds:
  - default WIDTH/NUM_IN constants;
  - a clog2 function for pre-SV tools;
  - the localparams ARB_RR=0 and ARB_FIXED=1.
- One sub-module, bus_rr_arbiter, is natural. Its inputs are req[NUM_IN], ptr, en and FIXED_PRIO. Its outputs are a one-hot grant and the encoded index. It is purely combinational.
- bus_rr_mux owns ptr, the output register and the data select.

Test Plan (WIDTH=4, NUM_IN=4 unless noted):
- Reset: hold rst_n=0 with all in_valid=1111 -> out_valid=0, out_data=0, in_ready=0000. Assert rst_n=0 mid-stall -> out_valid drops before the next edge.
- Single channel: in_valid=0100, in_data ch2=0xA, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=0xA, out_sel=2.
- Round-robin fairness: in_valid=1111 for 8 cycles, data ch i = i+1, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,2,3; out_data 1,2,3,4,1,2,3,4.
- Backpressure: word from ch1 (0x5) loaded, out_ready=0 for 3 cycles, in_valid=1111 -> out_data stays 0x5 and in_ready=0000 throughout; after out_ready=1 the next grant is ch2.
- Fixed priority (FIXED_PRIO=1): in_valid=1010 for 4 cycles -> out_sel=1 every cycle and ch3 is never granted. Then in_valid=1000 -> out_sel=3.
- Skip and wrap: ptr=3 (after a ch2 grant), in_valid=0011 -> grant ch0 (wrap); next cycle, with in_valid=0011 still, grant ch1.
